// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master controller: FSM state encoding,
// frame geometry, read/write flag values and the frame packing helper.
package spi_master_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

   localparam logic SPI_RW_WRITE   = 1'b0;
   localparam logic SPI_RW_READ    = 1'b1;
   localparam int   SPI_FRAME_BITS = 16;
   localparam int   SPI_CMD_BITS   = 8;
   localparam int   SPI_ADDR_BITS  = 7;
   localparam int   SPI_DATA_BITS  = 8;

   // Command byte {addr, rw} followed by the data byte, sent MSB first.
   function automatic logic [SPI_FRAME_BITS-1:0] spi_build_frame(
      input logic [SPI_ADDR_BITS-1:0] addr,
      input logic                     rw,
      input logic [SPI_DATA_BITS-1:0] data
   );
      return {addr, rw, data};
   endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Request/response handshake between a local requester and the SPI master.
interface spi_master_ctrl_if;
   import spi_master_ctrl_pkg::*;

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_rw;
   logic [SPI_ADDR_BITS-1:0] req_addr;
   logic [SPI_DATA_BITS-1:0] req_wdata;
   logic                     done;
   logic [SPI_DATA_BITS-1:0] rdata;
   logic                     busy;

   // Requester side: issues requests, observes completion.
   modport master (
      output req_valid, req_rw, req_addr, req_wdata,
      input  req_ready, done, rdata, busy
   );

   // Controller side.
   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata,
      output req_ready, done, rdata, busy
   );

endinterface

// File: rtl/spi_master_ctrl_clkgen.sv
// Half-period timer: counts CLKDIV clk cycles per SPI half period and
// emits a one-cycle half_tick at the end of each. A load restarts the
// count from the top; the count reloads itself on every tick so each
// phase is exactly CLKDIV cycles with no accumulated drift.
module spi_master_ctrl_clkgen #(
   parameter int CLKDIV = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic load,
   output logic half_tick
);

   localparam int               CNT_W  = $clog2(CLKDIV);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKDIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   // Down-counter with restart on load and auto-reload at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= RELOAD;
      end else if (enable) begin
         cnt_reg <= (cnt_reg == '0) ? RELOAD : cnt_reg - 1'b1;
      end
   end

   assign half_tick = enable && !load && (cnt_reg == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transaction sequencer. Takes one read or write request,
// sends the 16-bit frame {addr, rw, data} MSB first (mode 0: sclk idles
// low, data changes on falling edges), captures read data on the last
// byte and reports completion with a one-cycle done pulse. All SPI pins
// and status outputs are registered, so they follow the FSM by one clk.
module spi_master_ctrl
   import spi_master_ctrl_pkg::*;
#(
   parameter int CLKDIV = 50,
   parameter int CS_GAP = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   spi_master_ctrl_if.slave    bus,
   output logic                sclk_o,
   output logic                cs_o,
   output logic                mosi_o,
   input  logic                miso_i
);

   localparam int                   BIT_CNT_W = $clog2(SPI_FRAME_BITS);
   localparam logic [BIT_CNT_W-1:0] BIT_FIRST = BIT_CNT_W'(SPI_FRAME_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] RD_BITS   = BIT_CNT_W'(SPI_FRAME_BITS - SPI_CMD_BITS);
   localparam int                   GAP_W     = $clog2(CS_GAP + 2);
   localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(CS_GAP);

   spi_state_e                state_reg, state_next;
   logic [SPI_FRAME_BITS-1:0] tx_reg;
   logic [SPI_DATA_BITS-1:0]  rx_reg;
   logic [BIT_CNT_W-1:0]      bit_cnt_reg;
   logic                      rw_reg;
   logic                      phase_high_reg;
   logic                      last_bit_reg;
   logic                      sample_pend_reg;
   logic [GAP_W-1:0]          gap_cnt_reg;

   logic                      cs_reg, sclk_reg, mosi_reg, done_reg, busy_reg, ready_reg;
   logic [SPI_DATA_BITS-1:0]  rdata_reg;

   logic cs_next, sclk_next, mosi_next, done_next, clk_en;
   logic half_tick;
   logic accept;

   // ready is only ever high while the FSM sits in IDLE
   assign accept = bus.req_valid && ready_reg;

   spi_master_ctrl_clkgen #(
      .CLKDIV (CLKDIV)
   ) u_clkgen (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (clk_en),
      .load      (accept),
      .half_tick (half_tick)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: phases advance only on half_tick, GAP on its own count.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (accept)    state_next = ST_SETUP;
         ST_SETUP: if (half_tick) state_next = ST_SHIFT;
         ST_SHIFT: if (half_tick && !phase_high_reg && last_bit_reg) state_next = ST_HOLD;
         ST_HOLD:  if (half_tick) state_next = ST_GAP;
         ST_GAP:   if (gap_cnt_reg == '0) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Output decode: pin values for the next cycle and the timer enable.
   always_comb begin
      cs_next   = 1'b1;
      sclk_next = 1'b0;
      mosi_next = 1'b0;
      done_next = 1'b0;
      clk_en    = 1'b0;
      case (state_reg)
         ST_SETUP: begin
            cs_next   = 1'b0;
            mosi_next = tx_reg[SPI_FRAME_BITS-1];
            clk_en    = 1'b1;
         end
         ST_SHIFT: begin
            cs_next   = 1'b0;
            sclk_next = phase_high_reg;
            mosi_next = tx_reg[SPI_FRAME_BITS-1];
            clk_en    = 1'b1;
         end
         ST_HOLD: begin
            cs_next = 1'b0;
            clk_en  = 1'b1;
         end
         ST_GAP: begin
            // first GAP cycle only: coincides with cs rising on the pins
            done_next = (gap_cnt_reg == GAP_LOAD);
         end
         default: ;
      endcase
   end

   // Frame datapath: latch on accept, shift on falling edges, sample read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_reg          <= '0;
         rx_reg          <= '0;
         bit_cnt_reg     <= '0;
         rw_reg          <= SPI_RW_WRITE;
         phase_high_reg  <= 1'b0;
         last_bit_reg    <= 1'b0;
         sample_pend_reg <= 1'b0;
      end else begin
         sample_pend_reg <= 1'b0;
         if (accept) begin
            tx_reg         <= spi_build_frame(bus.req_addr, bus.req_rw, bus.req_wdata);
            rw_reg         <= bus.req_rw;
            bit_cnt_reg    <= BIT_FIRST;
            phase_high_reg <= 1'b0;
            last_bit_reg   <= 1'b0;
         end else if (half_tick && state_reg == ST_SETUP) begin
            phase_high_reg <= 1'b1;
         end else if (half_tick && state_reg == ST_SHIFT) begin
            if (phase_high_reg) begin
               // falling edge: present next bit, remember if that was bit 0
               phase_high_reg  <= 1'b0;
               tx_reg          <= {tx_reg[SPI_FRAME_BITS-2:0], 1'b0};
               bit_cnt_reg     <= bit_cnt_reg - 1'b1;
               last_bit_reg    <= (bit_cnt_reg == '0);
               // the pins lag the FSM by one clk, so sampling one clk after
               // the tick lands on the last clk of the pin-level high half
               sample_pend_reg <= (rw_reg == SPI_RW_READ) && (bit_cnt_reg < RD_BITS);
            end else begin
               phase_high_reg <= 1'b1;
            end
         end
         if (sample_pend_reg) begin
            rx_reg <= {rx_reg[SPI_DATA_BITS-2:0], miso_i};
         end
      end
   end

   // GAP length counter: loaded as HOLD ends, counts down to return to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt_reg <= '0;
      end else if (state_reg == ST_HOLD && half_tick) begin
         gap_cnt_reg <= GAP_LOAD;
      end else if (state_reg == ST_GAP && gap_cnt_reg != '0) begin
         gap_cnt_reg <= gap_cnt_reg - 1'b1;
      end
   end

   // Registered pin and status outputs; reset forces cs high immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_reg    <= 1'b1;
         sclk_reg  <= 1'b0;
         mosi_reg  <= 1'b0;
         done_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         ready_reg <= 1'b0;
         rdata_reg <= '0;
      end else begin
         cs_reg    <= cs_next;
         sclk_reg  <= sclk_next;
         mosi_reg  <= mosi_next;
         done_reg  <= done_next;
         busy_reg  <= (state_next != ST_IDLE);
         ready_reg <= (state_next == ST_IDLE);
         if (done_next && rw_reg == SPI_RW_READ) begin
            rdata_reg <= rx_reg;
         end
      end
   end

   assign cs_o          = cs_reg;
   assign sclk_o        = sclk_reg;
   assign mosi_o        = mosi_reg;
   assign bus.done      = done_reg;
   assign bus.busy      = busy_reg;
   assign bus.req_ready = ready_reg;
   assign bus.rdata     = rdata_reg;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl with a behavioural SPI memory slave. Accepted
// requests are pushed to a scoreboard; each done pulse pops one entry and
// checks the frame seen by the slave, latency, rdata and slave memory.
module tb_spi_master_ctrl;

   localparam int CLKDIV  = 8;
   localparam int CS_GAP  = 4;
   localparam int LAT     = 34*CLKDIV + 1;
   localparam int SPACING = 34*CLKDIV + CS_GAP + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic sclk, cs, mosi, miso;

   spi_master_ctrl_if bus();

   spi_master_ctrl #(
      .CLKDIV (CLKDIV),
      .CS_GAP (CS_GAP)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .sclk_o (sclk),
      .cs_o   (cs),
      .mosi_o (mosi),
      .miso_i (miso)
   );

   always #5 clk = ~clk;

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural SPI memory slave ----------------
   logic [7:0]  slv_mem [0:127] = '{default: 8'h00};
   logic [15:0] slv_cap = '0;
   int          slv_rises = 0;
   logic        slv_rw = 1'b0;
   logic [6:0]  slv_addr = '0;
   logic [7:0]  slv_sr = '0;
   logic [15:0] slv_last_frame = '0;
   int          slv_last_rises = 0;

   // Capture mosi on rising edges; commit complete write frames at cs rise.
   always @(negedge cs or posedge cs or posedge sclk) begin
      if (cs) begin
         if (slv_rises == 16 && !slv_rw) slv_mem[slv_addr] <= slv_cap[7:0];
         slv_last_frame <= slv_cap;
         slv_last_rises <= slv_rises;
      end else if (!sclk) begin
         slv_cap   <= '0;
         slv_rises <= 0;
      end else begin
         slv_cap   <= {slv_cap[14:0], mosi};
         slv_rises <= slv_rises + 1;
      end
   end

   // Decode the command after the 8th rise; shift read data out on falling edges.
   always @(negedge sclk) begin
      if (!cs) begin
         if (slv_rises == 8) begin
            slv_rw   <= slv_cap[0];
            slv_addr <= slv_cap[7:1];
            slv_sr   <= slv_mem[slv_cap[7:1]];
         end else if (slv_rises > 8) begin
            slv_sr <= {slv_sr[6:0], 1'b0};
         end
      end
   end

   assign miso = cs ? 1'b0 : slv_sr[7];

   // ---------------- scoreboard and monitors ----------------
   typedef struct {
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  wdata;
      logic [15:0] frame;
      int unsigned acc;
   } txn_t;

   txn_t        sb[$];
   int unsigned acc_hist[$];
   logic [7:0]  ref_mem [0:127] = '{default: 8'h00};
   logic [7:0]  model_rdata = '0;
   int unsigned cyc = 0;
   int          acc_cnt = 0;
   int          done_cnt = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      txn_t t;
      logic prev_done;
      int   hi_run;
      prev_done = 1'b0;
      hi_run    = 0;
      forever begin
         @(negedge clk);
         if (bus.req_valid && bus.req_ready) begin
            t.rw    = bus.req_rw;
            t.addr  = bus.req_addr;
            t.wdata = bus.req_wdata;
            t.frame = {bus.req_addr, bus.req_rw, bus.req_wdata};
            t.acc   = cyc + 1;
            sb.push_back(t);
            acc_hist.push_back(cyc + 1);
            acc_cnt++;
         end
         if (cs && mosi) check_val("mosi_idle", {31'd0, mosi}, 32'd0);
         if (bus.done && prev_done) check_val("done_one_cycle", {31'd0, prev_done}, 32'd0);
         if (bus.done && !prev_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
               t = sb.pop_front();
               check_val("frame", {16'd0, slv_last_frame}, {16'd0, t.frame});
               check_val("rises", slv_last_rises, 32'd16);
               check_val("latency", cyc - t.acc, LAT);
               check_val("cs_at_done", {31'd0, cs}, 32'd1);
               if (t.rw) begin
                  model_rdata = ref_mem[t.addr];
                  check_val("rdata", {24'd0, bus.rdata}, {24'd0, model_rdata});
               end else begin
                  check_val("rdata_hold", {24'd0, bus.rdata}, {24'd0, model_rdata});
                  ref_mem[t.addr] = t.wdata;
                  check_val("slave_mem", {24'd0, slv_mem[t.addr]}, {24'd0, t.wdata});
               end
               $display("txn %s addr=0x%02h wdata=0x%02h rdata=0x%02h latency=%0d",
                        t.rw ? "RD" : "WR", t.addr, t.wdata, bus.rdata, cyc - t.acc);
            end
         end
         prev_done = bus.done;
         if (cs) begin
            hi_run++;
         end else if (hi_run > 0) begin
            check_val("cs_gap", {31'd0, (hi_run >= CS_GAP + 1)}, 32'd1);
            hi_run = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready();
      int n = 0;
      while (!bus.req_ready && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.req_ready) check_val("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || bus.busy) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0 || bus.busy) check_val("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] data);
      @(posedge clk); #1;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_rw    = rw;
      bus.req_addr  = addr;
      bus.req_wdata = data;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int base, dcnt, n;
      bus.req_valid = 1'b0;
      bus.req_rw    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // reset state
      check_val("rst_cs",    {31'd0, cs},   32'd1);
      check_val("rst_sclk",  {31'd0, sclk}, 32'd0);
      check_val("rst_mosi",  {31'd0, mosi}, 32'd0);
      check_val("rst_done",  {31'd0, bus.done}, 32'd0);
      check_val("rst_busy",  {31'd0, bus.busy}, 32'd0);
      check_val("rst_ready", {31'd0, bus.req_ready}, 32'd0);
      check_val("rst_rdata", {24'd0, bus.rdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

      // single write, read-back, unrelated write, read-back again
      issue(1'b0, 7'h01, 8'h55);
      wait_idle();
      issue(1'b1, 7'h01, 8'h00);
      wait_idle();
      issue(1'b0, 7'h02, 8'h00);
      wait_idle();
      check_val("rdata_held", {24'd0, bus.rdata}, 32'h55);
      issue(1'b1, 7'h01, 8'h00);
      wait_idle();

      // back-to-back writes with req_valid held high
      base = acc_cnt;
      @(posedge clk); #1;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_rw    = 1'b0;
      bus.req_addr  = 7'h03;
      bus.req_wdata = 8'h3C;
      @(posedge clk); #1;
      bus.req_addr  = 7'h04;
      bus.req_wdata = 8'hC3;
      repeat (50) @(posedge clk);
      #1;
      check_val("b2b_ready_low", {31'd0, bus.req_ready}, 32'd0);
      check_val("b2b_busy",      {31'd0, bus.busy}, 32'd1);
      n = 0;
      while (acc_cnt < base + 2 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      bus.req_valid = 1'b0;
      check_val("b2b_accepts", acc_cnt - base, 32'd2);
      wait_idle();
      if (acc_hist.size() >= base + 2)
         check_val("b2b_spacing", acc_hist[base+1] - acc_hist[base], SPACING);
      issue(1'b1, 7'h03, 8'h00);
      wait_idle();
      issue(1'b1, 7'h04, 8'h00);
      wait_idle();

      // reset during SHIFT around bit 10 of a write to 0x7F
      issue(1'b0, 7'h7F, 8'h11);
      repeat (90) @(posedge clk);
      #1;
      check_val("abort_rises", slv_rises, 32'd6);
      dcnt = done_cnt;
      rst_n = 1'b0;
      sb.delete();
      model_rdata = '0;
      #1;
      check_val("abort_cs",   {31'd0, cs},   32'd1);
      check_val("abort_sclk", {31'd0, sclk}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (400) @(posedge clk);
      #1;
      check_val("abort_no_done", done_cnt - dcnt, 32'd0);
      check_val("abort_rdata",   {24'd0, bus.rdata}, 32'd0);
      issue(1'b1, 7'h7F, 8'h00);
      wait_idle();
      issue(1'b0, 7'h7F, 8'hA3);
      wait_idle();
      issue(1'b1, 7'h7F, 8'h00);
      wait_idle();

      // request inputs disturbed mid-frame
      dcnt = done_cnt;
      base = acc_cnt;
      issue(1'b0, 7'h05, 8'h5A);
      repeat (100) @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_rw    = 1'b1;
      bus.req_addr  = 7'h22;
      bus.req_wdata = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      wait_idle();
      repeat (50) @(posedge clk);
      #1;
      check_val("midframe_single_done", done_cnt - dcnt, 32'd1);
      check_val("midframe_single_acc",  acc_cnt - base, 32'd1);
      issue(1'b1, 7'h05, 8'h00);
      wait_idle();

      repeat (20) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
